frac_div_ctrl: RTL and testbench
================================

# frac_div_ctrl

Fractional-N divide-ratio controller for the PLL feedback path. It divides the DCO clock by a programmable integer N plus a fraction F/2^F_W, dithering each output period between N and N+1 with a first-order accumulator. It delivers the divided clock and a period-end strobe to the PFD side. New ratios arrive over a valid/ready handshake and take effect only at period boundaries, so the feedback clock never glitches.

## Interface
- `N_W`, default 8: width of integer ratio `N`.
- `F_W`, default 8: width of fractional word `F`; resolution is 1/2^F_W.
- `DEFAULT_N`, default 10: active `N` after reset (F resets to 0).

Ports:
- `clk_in`  in  1  DCO clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request.
- `cfg_valid`  in  1  new ratio offered.
- `cfg_ready`  out  1  shadow register empty, so an offer can be accepted.
- `cfg_n`  in  N_W  integer ratio; legal values are ≥ 2.
- `cfg_f`  in  F_W  fractional ratio.
- `cfg_err`  out  1  one-cycle pulse flagging an illegal `cfg_n`.
- `clk_out`  out  1  divided clock, registered.
- `div_pulse`  out  1  one-cycle strobe on the last `clk_in` cycle of each period.
- `cur_p`  out  N_W+1  length P of the current period.

## Operation
- **State machine:** two states, IDLE and RUN.
- **Registers:**
  - active config (`n_a`, `f_a`);
  - shadow config (`n_s`, `f_s`) plus `pend` flag;
  - accumulator `acc` [F_W];
  - counter `cnt` [N_W+1];
  - period length `P` [N_W+1].
- **Handshake:**
  - `cfg_ready = !pend`.
  - When `cfg_valid && cfg_ready` and `cfg_n ≥ 2`: capture into shadow and set `pend`.
  - When `cfg_n < 2`: discard the word, leave `pend` clear, pulse `cfg_err` on the next cycle.
- **Applying the shadow:** the shadow moves to active, `pend` clears and `acc` clears to 0 at these points:
  - in any IDLE cycle;
  - at a period boundary in RUN.
- **Period start** (on entering RUN, or at a boundary while `enable` = 1):
  - `sum = acc + f_a` (F_W+1 bits);
  - `P = n_a + sum[F_W]`;
  - `acc = sum[F_W-1:0]`;
  - `cnt = 0`.
  - These use the config that is active after any shadow apply made at the same edge.
- **IDLE:**
  - `clk_out` = 0, `cnt` = 0, `cur_p` = 0.
  - When `enable` = 1: go to RUN and start a period.
- **RUN:**
  - `cnt` increments each cycle.
  - `clk_out` = 1 for `cnt < ceil(P/2)`, and 0 otherwise.
  - When `cnt == P-1`: assert `div_pulse`; that edge is the boundary.
  - At the boundary: if `enable` = 1, start the next period; otherwise go to IDLE.
- **Long-run average ratio:** N + F/2^F_W.
- **Simultaneous events:**
  - A handshake in the same cycle as a boundary loads the shadow only. It applies at the following boundary, not this one.
  - `enable` dropping mid-period does not cut the period short; the period completes.
- **Reset:** mid-operation reset is immediate (synchronous). All state clears, `n_a` = `DEFAULT_N`, `f_a` = 0.

## Timing
- **Reset values:**
  - `clk_out`, `div_pulse`, `cfg_err` = 0;
  - `cur_p` = 0;
  - `cfg_ready` = 1;
  - state = IDLE.
- **Start-up:** `enable` sampled high at edge t, so `clk_out` goes high after edge t and `cur_p` = P from edge t.
- **Period shape:** `clk_out` is high for ceil(P/2) `clk_in` cycles, then low for floor(P/2).
- **`div_pulse`:** high during the cycle where `cnt == P-1`, which is the final low cycle of `clk_out`.
- **Config latency:**
  - In RUN, from handshake to first period using the new ratio: up to P + 1 edges.
  - In IDLE: active one edge after the handshake.
  - `cfg_ready` is low from the edge after acceptance until the applying edge.
- **`cfg_err`:** appears exactly one cycle after the rejected handshake.

## Structure
- **Shared package `pll_pkg`:**
  - state enum (IDLE, RUN);
  - `DEFAULT_N`;
  - minimum ratio constant `N_MIN` = 2.
- **Sub-module `frac_acc`:**
  - first-order accumulator;
  - inputs: `f`, step strobe, clear;
  - outputs: carry and `acc`.
- **Top level:** counter, FSM, shadow/handshake and output registers.

## Test plan
1. **Reset defaults:** reset, then `enable` = 1 → `clk_out` has period 10 with 5 high / 5 low, `div_pulse` every 10 cycles, `cur_p` = 10.
2. **Fractional ratio:** config N=4, F=64 with F_W=8 → periods repeat 4, 4, 4, 5, giving 17 cycles per 4 `div_pulse`s.
3. **Odd ratio:** N=5, F=0 → `clk_out` is 3 cycles high, 2 low; `div_pulse` falls in the last low cycle.
4. **Mid-period reconfig:** N=6 offered at cnt=3 of a 10-cycle period →
   - offer accepted and `cfg_ready` goes low;
   - a second offer stalls;
   - the current period still ends at 10;
   - the next period is 6 and `cfg_ready` returns to 1 at that boundary.
5. **Illegal and late-disable cases:**
   - `cfg_n` = 1 → `cfg_err` pulses once, the ratio is unchanged and `cfg_ready` stays 1.
   - `enable` dropped at cnt=2 → the period completes, then IDLE with `clk_out` = 0.
6. **Reset mid-period:** `rst` asserted at cnt=4 with N=6 active →
   - the next cycle shows all outputs at their reset values;
   - after re-enable the period is 10 (the default ratio).

Source files
------------

// File: rtl/pll_pkg.sv
// Shared definitions for the fractional-N feedback divider.
package pll_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_N = 10;
    localparam int N_MIN     = 2;

endpackage

// File: rtl/frac_acc.sv
// First-order fractional accumulator; carry picks the N+1 period when the
// fractional phase wraps past one.
module frac_acc
    import pll_pkg::*;
#(
    parameter int F_W = 8
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           step,
    input  logic           clr,
    input  logic [F_W-1:0] f,
    output logic           carry,
    output logic [F_W-1:0] acc
);

    logic [F_W-1:0] acc_q;
    logic [F_W-1:0] acc_d;
    logic [F_W-1:0] base;
    logic [F_W:0]   sum;

    // A clear at the same edge as a step makes the step start from zero phase.
    always_comb begin
        base  = clr ? '0 : acc_q;
        sum   = {1'b0, base} + {1'b0, f};
        carry = sum[F_W];
        acc_d = step ? sum[F_W-1:0] : base;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional-N divide-ratio controller: dithers each feedback period between
// N and N+1 and swaps in new ratios only at period boundaries.
module frac_div_ctrl
    import pll_pkg::*;
#(
    parameter int N_W       = 8,
    parameter int F_W       = 8,
    parameter int DEFAULT_N = pll_pkg::DEFAULT_N
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           enable,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [N_W-1:0] cfg_n,
    input  logic [F_W-1:0] cfg_f,
    output logic           cfg_err,
    output logic           clk_out,
    output logic           div_pulse,
    output logic [N_W:0]   cur_p,
    output state_t         dbg_state,
    output logic [F_W-1:0] dbg_acc
);

    state_t         state_q, state_d;
    logic [N_W-1:0] n_a_q, n_a_d, n_s_q, n_s_d;
    logic [F_W-1:0] f_a_q, f_a_d, f_s_q, f_s_d;
    logic           pend_q, pend_d;
    logic [N_W:0]   cnt_q, cnt_d;
    logic [N_W:0]   p_q, p_d;
    logic           clk_out_q, clk_out_d;
    logic           div_pulse_q, div_pulse_d;
    logic           cfg_err_q, cfg_err_d;

    logic           hs, cfg_ok, boundary, apply, start, carry;
    logic [N_W+1:0] half;
    logic [F_W-1:0] acc;

    // Handshake: a word transfers on any edge where cfg_valid && cfg_ready;
    // cfg_ready is simply "shadow empty", so it never depends on cfg_valid.
    always_comb begin
        hs        = cfg_valid && !pend_q;
        cfg_ok    = cfg_n >= N_W'(N_MIN);
        boundary  = (state_q == RUN) && (cnt_q == p_q - (N_W+1)'(1));
        apply     = pend_q && ((state_q == IDLE) || boundary);
        start     = enable && ((state_q == IDLE) || boundary);
        n_a_d     = apply ? n_s_q : n_a_q;
        f_a_d     = apply ? f_s_q : f_a_q;
        n_s_d     = n_s_q;
        f_s_d     = f_s_q;
        pend_d    = apply ? 1'b0 : pend_q;
        cfg_err_d = hs && !cfg_ok;
        if (hs && cfg_ok) begin
            n_s_d  = cfg_n;
            f_s_d  = cfg_f;
            pend_d = 1'b1;
        end
    end

    frac_acc #(
        .F_W (F_W)
    ) u_acc (
        .clk_in (clk_in),
        .rst    (rst),
        .step   (start),
        .clr    (apply),
        .f      (f_a_d),
        .carry  (carry),
        .acc    (acc)
    );

    // Outputs are registered from next-state values so clk_out is glitch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        p_d     = '0;
        if (start) begin
            state_d = RUN;
            p_d     = {1'b0, n_a_d} + (N_W+1)'(carry);
        end else if (boundary) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + (N_W+1)'(1);
            p_d   = p_q;
        end
        half        = ({1'b0, p_d} + (N_W+2)'(1)) >> 1;
        clk_out_d   = (state_d == RUN) && ({1'b0, cnt_d} < half);
        div_pulse_d = (state_d == RUN) && (cnt_d == p_d - (N_W+1)'(1));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= IDLE;
            n_a_q       <= N_W'(DEFAULT_N);
            f_a_q       <= '0;
            n_s_q       <= '0;
            f_s_q       <= '0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            p_q         <= '0;
            clk_out_q   <= 1'b0;
            div_pulse_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_a_q       <= n_a_d;
            f_a_q       <= f_a_d;
            n_s_q       <= n_s_d;
            f_s_q       <= f_s_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            clk_out_q   <= clk_out_d;
            div_pulse_q <= div_pulse_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = clk_out_q;
    assign div_pulse = div_pulse_q;
    assign cur_p     = p_q;
    assign dbg_state = state_q;
    assign dbg_acc   = acc;

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Bench for frac_div_ctrl: expected period lengths are queued as stimulus is
// driven and checked against each div_pulse by a period monitor.
module tb_frac_div_ctrl;
    import pll_pkg::*;

    localparam int N_W = 8;
    localparam int F_W = 8;

    logic           clk_in = 1'b0;
    logic           rst;
    logic           enable;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [N_W-1:0] cfg_n;
    logic [F_W-1:0] cfg_f;
    logic           cfg_err;
    logic           clk_out;
    logic           div_pulse;
    logic [N_W:0]   cur_p;
    state_t         dbg_state;
    logic [F_W-1:0] dbg_acc;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N_W:0] exp_q[$];

    int cyc, hi, lo;
    bit fell;
    logic [N_W:0] p_exp;

    frac_div_ctrl #(
        .N_W       (N_W),
        .F_W       (F_W),
        .DEFAULT_N (10)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_n     (cfg_n),
        .cfg_f     (cfg_f),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .div_pulse (div_pulse),
        .cur_p     (cur_p),
        .dbg_state (dbg_state),
        .dbg_acc   (dbg_acc)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // period monitor: high prefix must be ceil(P/2), remaining lows floor(P/2)
    always @(negedge clk_in) begin
        if (rst || cur_p == '0) begin
            cyc = 0; hi = 0; lo = 0; fell = 0;
        end else begin
            cyc++;
            if (!clk_out) begin
                fell = 1;
                lo++;
            end else if (!fell) begin
                hi++;
            end
            if (div_pulse) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 32'(div_pulse), 0);
                end else begin
                    p_exp = exp_q.pop_front();
                    check("period", cyc, 32'(p_exp));
                    check("high_len", hi, (32'(p_exp) + 1) / 2);
                    check("low_len", lo, 32'(p_exp) / 2);
                    check("cur_p", 32'(cur_p), 32'(p_exp));
                    check("pulse_in_low", 32'(clk_out), 0);
                end
                cyc = 0; hi = 0; lo = 0; fell = 0;
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_cfg(input int n, input int f);
        bit done = 0;
        cfg_valid = 1'b1;
        cfg_n     = N_W'(n);
        cfg_f     = F_W'(f);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_in);
            done = cfg_ready;
            @(posedge clk_in);
            #1;
        end
        cfg_valid = 1'b0;
        check("cfg_accept", 32'(done), 1);
    endtask

    task automatic push_p(input int p, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back((N_W+1)'(p));
    endtask

    task automatic wait_drain(input int max_cyc);
        int i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            @(negedge clk_in);
            #1;
            i++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic stop_run();
        enable = 1'b0;
        tick(1);
        @(negedge clk_in);
        check("idle_cur_p", 32'(cur_p), 0);
        check("idle_clk", 32'(clk_out), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk"}, 32'(clk_out), 0);
        check({tag, "_pulse"}, 32'(div_pulse), 0);
        check({tag, "_err"}, 32'(cfg_err), 0);
        check({tag, "_cur_p"}, 32'(cur_p), 0);
        check({tag, "_ready"}, 32'(cfg_ready), 1);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        bit got_pulse;
        int guard;
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_n     = '0;
        cfg_f     = '0;
        tick(3);
        @(negedge clk_in);
        check_reset_outputs("rst");
        check("rst_acc", 32'(dbg_acc), 0);
        rst = 1'b0;

        // default ratio 10
        push_p(10, 3);
        enable = 1'b1;
        wait_drain(100);
        stop_run();

        // N=4, F=64/256 -> 4,4,4,5 repeating
        send_cfg(4, 64);
        push_p(4, 3); push_p(5, 1); push_p(4, 3); push_p(5, 1);
        enable = 1'b1;
        wait_drain(100);
        stop_run();
        check("acc_wrap", 32'(dbg_acc), 0);

        // odd ratio 5
        send_cfg(5, 0);
        push_p(5, 3);
        enable = 1'b1;
        wait_drain(100);
        stop_run();

        // mid-period reconfig: 10 then 6, second offer (7) stalls until boundary
        send_cfg(10, 0);
        push_p(10, 1); push_p(6, 1); push_p(7, 1);
        enable = 1'b1;
        tick(4);
        check("reconf_ready0", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_n     = N_W'(6);
        cfg_f     = '0;
        tick(1);
        check("reconf_ready_low", 32'(cfg_ready), 0);
        cfg_n = N_W'(7);
        got_pulse = 0;
        for (int i = 0; i < 20 && !got_pulse; i++) begin
            @(negedge clk_in);
            check("reconf_stall", 32'(cfg_ready), 0);
            got_pulse = div_pulse;
        end
        check("reconf_boundary", 32'(got_pulse), 1);
        tick(1);
        check("reconf_ready_back", 32'(cfg_ready), 1);
        check("reconf_new_p", 32'(cur_p), 6);
        tick(1);
        cfg_valid = 1'b0;
        check("reconf_second_taken", 32'(cfg_ready), 0);
        wait_drain(100);
        stop_run();

        // illegal cfg_n=1 while running at N=7, then late disable
        push_p(7, 3);
        enable = 1'b1;
        tick(2);
        cfg_valid = 1'b1;
        cfg_n     = N_W'(1);
        tick(1);
        cfg_valid = 1'b0;
        @(negedge clk_in);
        check("err_pulse", 32'(cfg_err), 1);
        check("err_ready", 32'(cfg_ready), 1);
        @(negedge clk_in);
        check("err_once", 32'(cfg_err), 0);
        guard = 0;
        while (exp_q.size() > 1 && guard < 50) begin
            @(negedge clk_in);
            #1;
            guard++;
        end
        check("late_sync", exp_q.size(), 1);
        tick(3);
        enable = 1'b0;
        wait_drain(50);
        tick(1);
        @(negedge clk_in);
        check("late_cur_p", 32'(cur_p), 0);
        check("late_clk", 32'(clk_out), 0);
        check("late_state", 32'(dbg_state), 32'(IDLE));
        tick(3);
        check("late_hold_clk", 32'(clk_out), 0);

        // reset at cnt=4 with N=6 active, then default ratio again
        send_cfg(6, 0);
        enable = 1'b1;
        tick(5);
        check("pre_rst_p", 32'(cur_p), 6);
        rst    = 1'b1;
        enable = 1'b0;
        tick(1);
        @(negedge clk_in);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        push_p(10, 2);
        enable = 1'b1;
        wait_drain(100);
        stop_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
